// File: rtl/apb_pcie_trace.sv
// APB status slave plus a multi-channel DMA debug trace capture buffer.
// Optional trigger / post-trigger stop logic is built when APB_PCIE_TRACE_TRIG_EN is defined.

package apb_pcie_trace_pkg;
    localparam logic [15:0] VENDOR_OPTIMITECH    = 16'h00F1;
    localparam logic [15:0] OPTIMITECH_PCIE_CTRL = 16'h0082;
    localparam logic [1:0]  PNP_CFG_TYPE_SLAVE   = 2'b10;

    typedef struct packed {
        logic [63:0] addr_start;
        logic [63:0] addr_end;
    } mapinfo_type;

    typedef struct packed {
        logic [1:0]  descrtype;
        logic [6:0]  descrsize;
        logic [15:0] vid;
        logic [15:0] did;
        logic [63:0] addr_start;
        logic [63:0] addr_end;
    } dev_config_type;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_out_type;
endpackage

module apb_pcie_trace
    import apb_pcie_trace_pkg::*;
#(
    parameter int          CH_NUM     = 2,
    parameter int          LOG2_DEPTH = 4,
    parameter logic [15:0] did        = OPTIMITECH_PCIE_CTRL
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  mapinfo_type             i_mapinfo,
    output dev_config_type          o_cfg,
    input  apb_in_type              i_apbi,
    output apb_out_type             o_apbo,
    input  logic [15:0]             i_pcie_completer_id,
    input  logic [3:0]              i_dma_state,
    input  logic [CH_NUM-1:0]       i_dbg_valid,
    input  logic [64*CH_NUM-1:0]    i_dbg_data
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;

    logic            req_valid, req_write;
    logic [11:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            resp_valid;
    logic [31:0]     resp_rdata, rdata;

    logic            enable, mode, trig_arm, triggered;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     drop_cnt;
    logic [31:0]     tstamp;

    logic [63:0]     buf_data [DEPTH];
    logic [31:0]     buf_ts   [DEPTH];
    logic [2:0]      buf_ch   [DEPTH];

    logic            any_valid, full, empty, ctrl_wr, do_clear, store;
    logic [2:0]      win_ch;
    logic [63:0]     win_data;
    logic [3:0]      n_valid, drop_inc;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_next;

    // Bus helper: setup phase is the request, data answers in the access phase.
    assign req_valid = i_apbi.psel & ~i_apbi.penable;
    assign req_write = i_apbi.pwrite;
    assign req_addr  = i_apbi.paddr[11:0];
    assign req_wdata = i_apbi.pwdata;

    assign o_apbo.pready  = resp_valid;
    assign o_apbo.prdata  = resp_rdata;
    assign o_apbo.pslverr = 1'b0;

    assign o_cfg.descrtype  = PNP_CFG_TYPE_SLAVE;
    assign o_cfg.descrsize  = 7'h14;
    assign o_cfg.vid        = VENDOR_OPTIMITECH;
    assign o_cfg.did        = did;
    assign o_cfg.addr_start = i_mapinfo.addr_start;
    assign o_cfg.addr_end   = i_mapinfo.addr_end;

    logic unused_apb;
    assign unused_apb = ^{i_apbi.paddr[31:12], i_apbi.pprot, i_apbi.pstrb, req_wdata};

    always_comb begin
        win_ch   = '0;
        win_data = '0;
        n_valid  = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (i_dbg_valid[i]) begin
                win_ch   = 3'(i);
                win_data = i_dbg_data[i*64 +: 64];
            end
            n_valid = n_valid + {3'd0, i_dbg_valid[i]};
        end
    end

    assign any_valid = |i_dbg_valid;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign ctrl_wr   = req_valid & req_write & (req_addr[11:2] == 10'd2);
    assign do_clear  = ctrl_wr & req_wdata[2];
    assign store     = enable & any_valid & ~do_clear & (~full | ~mode);

    // Losers of arbitration always count; the winner counts too if stop-on-full rejects it.
    always_comb begin
        drop_inc = '0;
        if (enable && any_valid && !do_clear)
            drop_inc = n_valid - 4'd1 + {3'd0, full & mode};
    end
    assign drop_sum  = {1'b0, drop_cnt} + {13'd0, drop_inc};
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

`ifdef APB_PCIE_TRACE_TRIG_EN
    logic [31:0] trig_value, trig_mask;
    logic [15:0] post_cnt, trig_cnt;
    logic        trig_run, match;
    assign match = trig_arm & ((win_data[31:0] & trig_mask) == (trig_value & trig_mask));
`else
    assign trig_arm  = 1'b0;
    assign triggered = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            enable   <= 1'b1;
            mode     <= 1'b0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            tstamp   <= '0;
`ifdef APB_PCIE_TRACE_TRIG_EN
            trig_arm   <= 1'b0;
            triggered  <= 1'b0;
            trig_value <= '0;
            trig_mask  <= '0;
            post_cnt   <= '0;
            trig_cnt   <= '0;
            trig_run   <= 1'b0;
`endif
        end else begin
            tstamp <= tstamp + 32'd1;
            if (ctrl_wr) begin
                enable <= req_wdata[0];
                mode   <= req_wdata[1];
`ifdef APB_PCIE_TRACE_TRIG_EN
                trig_arm <= req_wdata[3];
`endif
            end
`ifdef APB_PCIE_TRACE_TRIG_EN
            if (req_valid && req_write) begin
                case (req_addr[11:2])
                    10'd6:   trig_value <= req_wdata;
                    10'd7:   trig_mask  <= req_wdata;
                    10'd8:   post_cnt   <= req_wdata[15:0];
                    default: ;
                endcase
            end
`endif
            if (do_clear) begin
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= '0;
`ifdef APB_PCIE_TRACE_TRIG_EN
                triggered <= 1'b0;
                trig_run  <= 1'b0;
`endif
            end else begin
                drop_cnt <= drop_next;
                if (store) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (!full)
                        count <= count + CW'(1);
`ifdef APB_PCIE_TRACE_TRIG_EN
                    // Trigger disables capture late in the block so it beats a same-cycle ctrl write.
                    if (match) begin
                        triggered <= 1'b1;
                        trig_arm  <= 1'b0;
                        if (post_cnt == 16'd0) begin
                            enable <= 1'b0;
                        end else begin
                            trig_cnt <= post_cnt;
                            trig_run <= 1'b1;
                        end
                    end else if (trig_run) begin
                        trig_cnt <= trig_cnt - 16'd1;
                        if (trig_cnt == 16'd1) begin
                            enable   <= 1'b0;
                            trig_run <= 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (store) begin
            buf_data[wr_ptr] <= win_data;
            buf_ts[wr_ptr]   <= tstamp;
            buf_ch[wr_ptr]   <= win_ch;
        end
    end

    always_comb begin
        rdata = '0;
        if (req_addr[11:10] == 2'b01) begin
            if ({26'd0, req_addr[9:4]} < 32'(DEPTH)) begin
                case (req_addr[3:2])
                    2'd0:    rdata = buf_data[req_addr[4 +: LOG2_DEPTH]][31:0];
                    2'd1:    rdata = buf_data[req_addr[4 +: LOG2_DEPTH]][63:32];
                    2'd2:    rdata = buf_ts[req_addr[4 +: LOG2_DEPTH]];
                    default: rdata = {29'd0, buf_ch[req_addr[4 +: LOG2_DEPTH]]};
                endcase
            end
        end else begin
            case (req_addr[11:2])
                10'd0:   rdata = {21'd0, triggered, empty, full, 4'd0, i_dma_state};
                10'd1:   rdata = {16'd0, i_pcie_completer_id};
                10'd2:   rdata = {28'd0, trig_arm, 1'b0, mode, enable};
                10'd3:   rdata = 32'(count);
                10'd4:   rdata = 32'(wr_ptr);
                10'd5:   rdata = {16'd0, drop_cnt};
`ifdef APB_PCIE_TRACE_TRIG_EN
                10'd6:   rdata = trig_value;
                10'd7:   rdata = trig_mask;
                10'd8:   rdata = {16'd0, post_cnt};
`endif
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid)
                resp_rdata <= rdata;
        end
    end
endmodule

// File: tb/tb_apb_pcie_trace.sv
// Randomized bench for apb_pcie_trace against a queue-based model of the trace buffer.
// Trigger checks are compiled in when APB_PCIE_TRACE_TRIG_EN is defined.

module tb_apb_pcie_trace;
    import apb_pcie_trace_pkg::*;

    localparam int CH    = 2;
    localparam int L2D   = 4;
    localparam int DEPTH = 1 << L2D;

    typedef struct {
        logic [63:0] d;
        logic [31:0] ts;
        logic [2:0]  ch;
    } ent_t;

    logic             clk, nrst;
    mapinfo_type      mapinfo;
    dev_config_type   cfg;
    apb_in_type       apbi;
    apb_out_type      apbo;
    logic [15:0]      cid;
    logic [3:0]       dma_state;
    logic [CH-1:0]    dbg_valid;
    logic [64*CH-1:0] dbg_data;

    int          n_chk, n_pass;
    logic [31:0] cyc;

    ent_t        q[$];
    int          m_total, m_drop;
    logic        m_en, m_mode, m_trig;

    apb_pcie_trace #(.CH_NUM(CH), .LOG2_DEPTH(L2D), .did(OPTIMITECH_PCIE_CTRL)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_mapinfo(mapinfo), .o_cfg(cfg),
        .i_apbi(apbi), .o_apbo(apbo), .i_pcie_completer_id(cid),
        .i_dma_state(dma_state), .i_dbg_valid(dbg_valid), .i_dbg_data(dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Post-reset cycle count: the timestamp a capture on the next edge must carry.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= '0;
        else       cyc <= cyc + 32'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h need %0h", tag, got, exp);
    endtask

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int t;
        @(posedge clk); #1;
        apbi.paddr = {20'd0, addr}; apbi.pwrite = wr; apbi.pwdata = wdata;
        apbi.psel = 1'b1; apbi.penable = 1'b0;
        @(posedge clk); #1;
        apbi.penable = 1'b1;
        t = 0;
        while (!apbo.pready && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        if (!apbo.pready) chk("pready_timeout", 64'(apbo.pready), 64'd1);
        rdata = apbo.prdata;
        @(posedge clk); #1;
        apbi.psel = 1'b0; apbi.penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, wdata, dummy);
    endtask

    task automatic apb_rd(input logic [11:0] addr, output logic [31:0] rdata);
        apb_xfer(1'b0, addr, 32'd0, rdata);
    endtask

    task automatic model_clear();
        q.delete();
        m_total = 0;
        m_drop  = 0;
        m_trig  = 1'b0;
    endtask

    task automatic set_ctrl(input logic en, input logic md, input logic clr);
        apb_wr(12'h008, {28'd0, 1'b0, clr, md, en});
        m_en = en;
        m_mode = md;
        if (clr) model_clear();
    endtask

    task automatic model_cap(input logic [CH-1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [31:0] ts);
        ent_t e;
        int   drops;
        if (!m_en || v == '0) return;
        drops = int'(v[0]) + int'(v[1]) - 1;
        e.d  = v[0] ? d0 : d1;
        e.ch = v[0] ? 3'd0 : 3'd1;
        e.ts = ts;
        if (q.size() < DEPTH) begin
            q.push_back(e);
            m_total++;
        end else if (!m_mode) begin
            q.delete(0);
            q.push_back(e);
            m_total++;
        end else begin
            drops++;
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    endtask

    task automatic pulse(input logic [CH-1:0] v, input logic [63:0] d0, input logic [63:0] d1);
        logic [31:0] ts;
        @(posedge clk); #1;
        ts = cyc;
        dbg_valid = v;
        dbg_data  = {d1, d0};
        @(posedge clk); #1;
        dbg_valid = '0;
        model_cap(v, d0, d1, ts);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] r;
        int          slot;
        dma_state = 4'($urandom_range(0, 15));
        apb_rd(12'h000, r);
        chk({tag, "_status"}, r, {21'd0, m_trig, q.size() == 0, q.size() == DEPTH, 4'd0, dma_state});
        apb_rd(12'h008, r);
        chk({tag, "_ctrl"}, r, {28'd0, 2'b00, m_mode, m_en});
        apb_rd(12'h00C, r);
        chk({tag, "_count"}, r, 32'(q.size()));
        apb_rd(12'h010, r);
        chk({tag, "_wr_ptr"}, r, 32'(m_total % DEPTH));
        apb_rd(12'h014, r);
        chk({tag, "_drop"}, r, 32'(m_drop));
        foreach (q[j]) begin
            slot = (m_total - q.size() + j) % DEPTH;
            apb_rd(12'(12'h400 + slot * 16), r);
            chk({tag, "_d_lo"}, r, q[j].d[31:0]);
            apb_rd(12'(12'h404 + slot * 16), r);
            chk({tag, "_d_hi"}, r, q[j].d[63:32]);
            apb_rd(12'(12'h408 + slot * 16), r);
            chk({tag, "_ts"}, r, q[j].ts);
            apb_rd(12'(12'h40C + slot * 16), r);
            chk({tag, "_ch"}, r, {29'd0, q[j].ch});
        end
    endtask

    initial begin
        logic [31:0] r, t0, t1, t2;
        logic [63:0] d21;
        n_chk = 0; n_pass = 0;
        nrst = 1'b0;
        apbi = '0;
        dbg_valid = '0;
        dbg_data = '0;
        dma_state = 4'h5;
        cid = 16'hBEEF;
        mapinfo.addr_start = 64'h0000_8000_0000_1000;
        mapinfo.addr_end   = 64'h0000_8000_0000_1FFF;
        m_en = 1'b1; m_mode = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;

        chk("cfg_vid", cfg.vid, VENDOR_OPTIMITECH);
        chk("cfg_did", cfg.did, OPTIMITECH_PCIE_CTRL);
        chk("cfg_addr", cfg.addr_start, mapinfo.addr_start);
        apb_rd(12'h000, r);
        chk("rst_status", r, 32'h205);
        apb_rd(12'h008, r);
        chk("rst_ctrl", r, 32'h1);
        apb_rd(12'h004, r);
        chk("completer_id", r, 32'h0000BEEF);
        check_all("rst");

        for (int j = 0; j < 3; j++) pulse(2'b01, 64'h0A0 + 64'(j), rnd64());
        apb_rd(12'h00C, r); chk("three_count", r, 32'd3);
        apb_rd(12'h010, r); chk("three_wr_ptr", r, 32'd3);
        apb_rd(12'h410, r); chk("entry1_w0", r, 32'hA1);
        apb_rd(12'h408, t0); apb_rd(12'h418, t1); apb_rd(12'h428, t2);
        chk("ts_increasing", 64'((t1 > t0) && (t2 > t1)), 64'd1);
        check_all("three");

        set_ctrl(1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) pulse(2'b11, rnd64(), rnd64());
        apb_rd(12'h014, r); chk("both_drop", r, 32'd5);
        check_all("both");

        set_ctrl(1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 20; j++) pulse(2'b01, {32'h0, 32'hC0DE_0000 + 32'(j)}, rnd64());
        apb_rd(12'h00C, r); chk("stop_count", r, 32'd16);
        apb_rd(12'h000, r); chk("stop_full", 64'(r[8]), 64'd1);
        apb_rd(12'h014, r); chk("stop_drop", r, 32'd4);
        check_all("stop");
        set_ctrl(1'b1, 1'b0, 1'b0);
        pulse(2'b01, 64'hD00D_0021_1234_5678, rnd64());
        d21 = 64'hD00D_0021_1234_5678;
        pulse(2'b01, rnd64(), rnd64());
        apb_rd(12'h010, r); chk("wrap_wr_ptr", r, 32'd2);
        apb_rd(12'h400, r); chk("wrap_slot0", r, d21[31:0]);
        check_all("wrap");

        @(posedge clk); #1;
        apbi.paddr = 32'h008; apbi.pwrite = 1'b1; apbi.pwdata = 32'h5;
        apbi.psel = 1'b1; apbi.penable = 1'b0;
        dbg_valid = 2'b11; dbg_data = {rnd64(), rnd64()};
        @(posedge clk); #1;
        dbg_valid = '0; apbi.penable = 1'b1;
        @(posedge clk); #1;
        apbi.psel = 1'b0; apbi.penable = 1'b0;
        m_en = 1'b1; m_mode = 1'b0;
        model_clear();
        apb_rd(12'h00C, r); chk("clr_count", r, 32'd0);
        apb_rd(12'h014, r); chk("clr_drop", r, 32'd0);
        apb_rd(12'h010, r); chk("clr_wr_ptr", r, 32'd0);
        check_all("clr");

        for (int k = 0; k < 5; k++) begin
            set_ctrl(($urandom_range(0, 4) != 0) || (k == 4), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0));
            for (int j = 0; j < 30; j++)
                pulse(2'($urandom_range(0, 3)), rnd64(), rnd64());
            check_all("rand");
        end
        set_ctrl(1'b1, 1'b0, 1'b0);

        apb_rd(12'h500, r); chk("entry_oob", r, 32'd0);
        apb_rd(12'h024, r); chk("unmapped", r, 32'd0);
        apb_rd(12'hC00, r); chk("unmapped_hi", r, 32'd0);
        apb_wr(12'h00C, 32'hFFFF_FFFF);
        apb_wr(12'h010, 32'hFFFF_FFFF);
        check_all("ro_write");

`ifdef APB_PCIE_TRACE_TRIG_EN
        set_ctrl(1'b1, 1'b0, 1'b1);
        apb_wr(12'h018, 32'h55);
        apb_wr(12'h01C, 32'hFF);
        apb_wr(12'h020, 32'd2);
        apb_rd(12'h018, r); chk("trig_value", r, 32'h55);
        apb_rd(12'h020, r); chk("post_cnt", r, 32'd2);
        apb_wr(12'h008, 32'h9);
        apb_rd(12'h008, r); chk("trig_armed", r, 32'h9);
        pulse(2'b01, 64'h10, rnd64());
        pulse(2'b01, 64'hABCD_0000_0000_0055, rnd64());
        pulse(2'b01, 64'h11, rnd64());
        pulse(2'b01, 64'h12, rnd64());
        m_en = 1'b0;
        m_trig = 1'b1;
        pulse(2'b01, 64'h13, rnd64());
        apb_rd(12'h000, r); chk("trig_flag", 64'(r[10]), 64'd1);
        apb_rd(12'h00C, r); chk("trig_count", r, 32'd4);
        apb_rd(12'h008, r); chk("trig_ctrl", r, 32'h0);
        check_all("trig");
        set_ctrl(1'b1, 1'b0, 1'b1);
        apb_rd(12'h000, r); chk("trig_clr_flag", 64'(r[10]), 64'd0);
`else
        apb_wr(12'h018, 32'h55);
        apb_wr(12'h020, 32'h2);
        apb_rd(12'h018, r); chk("notrig_value", r, 32'd0);
        apb_rd(12'h020, r); chk("notrig_post", r, 32'd0);
        apb_wr(12'h008, 32'h9);
        m_en = 1'b1; m_mode = 1'b0;
        apb_rd(12'h008, r); chk("notrig_arm", r, 32'h1);
        pulse(2'b10, rnd64(), 64'h55);
        check_all("notrig");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
